// File: rtl/win_fetch_ctrl_if.sv
// Window fetch bus: BRAM read port, frame control and window handshake.
// master = window fetch controller side, slave = BRAM/Sobel/host side.
interface win_fetch_ctrl_if #(
  parameter int ADDR_W = 14
);
  // frame control
  logic              start;
  logic              busy;
  logic              frame_done;
  // BRAM read port
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd_en;
  logic [7:0]        mem_rd_data;
  // window output, raster order, centre pix_4 omitted
  logic [7:0]        pix_0;
  logic [7:0]        pix_1;
  logic [7:0]        pix_2;
  logic [7:0]        pix_3;
  logic [7:0]        pix_5;
  logic [7:0]        pix_6;
  logic [7:0]        pix_7;
  logic [7:0]        pix_8;
  logic [ADDR_W-1:0] win_addr;
  logic              win_border;
  logic              win_valid;
  logic              win_ready;

  modport master (
    input  start,
    input  mem_rd_data,
    input  win_ready,
    output busy,
    output frame_done,
    output mem_addr,
    output mem_rd_en,
    output pix_0,
    output pix_1,
    output pix_2,
    output pix_3,
    output pix_5,
    output pix_6,
    output pix_7,
    output pix_8,
    output win_addr,
    output win_border,
    output win_valid
  );

  modport slave (
    output start,
    output mem_rd_data,
    output win_ready,
    input  busy,
    input  frame_done,
    input  mem_addr,
    input  mem_rd_en,
    input  pix_0,
    input  pix_1,
    input  pix_2,
    input  pix_3,
    input  pix_5,
    input  pix_6,
    input  pix_7,
    input  pix_8,
    input  win_addr,
    input  win_border,
    input  win_valid
  );
endinterface

// File: rtl/win_fetch_ctrl.sv
// 3x3 window sequencer: scans a WIDTH x HEIGHT image in a single-port
// BRAM, fetching the 8 neighbours of each centre one read per cycle.
// Ports: clk, rst (sync, active-high), bus (win_fetch_ctrl_if.master):
//   start/busy/frame_done frame control, mem_* BRAM read port
//   (1-cycle read latency), pix_*/win_addr/win_border window data,
//   win_valid/win_ready window handshake.
module win_fetch_ctrl #(
  parameter int WIDTH  = 128,
  parameter int HEIGHT = 96,
  parameter int ADDR_W = 14
) (
  input logic            clk,
  input logic            rst,
  win_fetch_ctrl_if.master bus
);

  localparam int CW = $clog2(WIDTH);
  localparam int RW = $clog2(HEIGHT);

  localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);
  localparam logic [ADDR_W-1:0] W_A = ADDR_W'(WIDTH);
  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    FETCH,
    DRAIN,
    PRESENT
  } state_t;

  state_t            state_q;
  logic [RW-1:0]     row_q;
  logic [CW-1:0]     col_q;
  logic [ADDR_W-1:0] ctr_q;
  logic [2:0]        k_q;
  logic [ADDR_W-1:0] addr_q;
  logic              rd_en_q;
  logic [7:0]        pix_q [8];
  logic [ADDR_W-1:0] win_addr_q;
  logic              border_q;
  logic              valid_q;
  logic              busy_q;
  logic              done_q;

  logic              edge_d;
  logic              last_d;
  logic [2:0]        k_nxt_d;

  // Neighbour address for read k, raster order skipping the centre.
  function automatic logic [ADDR_W-1:0] nb_addr(
    input logic [ADDR_W-1:0] c,
    input logic [2:0]        k
  );
    logic [ADDR_W-1:0] a;
    case (k)
      3'd0:    a = c - W_A - ONE;
      3'd1:    a = c - W_A;
      3'd2:    a = c - W_A + ONE;
      3'd3:    a = c - ONE;
      3'd4:    a = c + ONE;
      3'd5:    a = c + W_A - ONE;
      3'd6:    a = c + W_A;
      default: a = c + W_A + ONE;
    endcase
    return a;
  endfunction

  // Border decided from the counters, never from address arithmetic.
  always_comb begin
    edge_d  = (row_q == '0) || (row_q == ROW_LAST) ||
              (col_q == '0) || (col_q == COL_LAST);
    last_d  = (row_q == ROW_LAST) && (col_q == COL_LAST);
    k_nxt_d = k_q + 3'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      row_q      <= '0;
      col_q      <= '0;
      ctr_q      <= '0;
      k_q        <= '0;
      addr_q     <= '0;
      rd_en_q    <= 1'b0;
      win_addr_q <= '0;
      border_q   <= 1'b0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      for (int i = 0; i < 8; i++) pix_q[i] <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_q <= CHECK;
            busy_q  <= 1'b1;
            row_q   <= '0;
            col_q   <= '0;
            ctr_q   <= '0;
          end
        end
        CHECK: begin
          win_addr_q <= ctr_q;
          if (edge_d) begin
            border_q <= 1'b1;
            for (int i = 0; i < 8; i++) pix_q[i] <= '0;
            valid_q  <= 1'b1;
            state_q  <= PRESENT;
          end else begin
            border_q <= 1'b0;
            k_q      <= '0;
            rd_en_q  <= 1'b1;
            addr_q   <= nb_addr(ctr_q, 3'd0);
            state_q  <= FETCH;
          end
        end
        FETCH: begin
          // data on the bus now belongs to the read issued last cycle
          if (k_q != 3'd0) pix_q[k_q - 3'd1] <= bus.mem_rd_data;
          if (k_q == 3'd7) begin
            rd_en_q <= 1'b0;
            state_q <= DRAIN;
          end else begin
            addr_q <= nb_addr(ctr_q, k_nxt_d);
            k_q    <= k_nxt_d;
          end
        end
        DRAIN: begin
          pix_q[7] <= bus.mem_rd_data;
          valid_q  <= 1'b1;
          state_q  <= PRESENT;
        end
        PRESENT: begin
          if (bus.win_ready) begin
            valid_q <= 1'b0;
            if (last_d) begin
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end else begin
              ctr_q <= ctr_q + ONE;
              if (col_q == COL_LAST) begin
                col_q <= '0;
                row_q <= row_q + 1'b1;
              end else begin
                col_q <= col_q + 1'b1;
              end
              state_q <= CHECK;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy       = busy_q;
  assign bus.frame_done = done_q;
  assign bus.mem_addr   = addr_q;
  assign bus.mem_rd_en  = rd_en_q;
  assign bus.pix_0      = pix_q[0];
  assign bus.pix_1      = pix_q[1];
  assign bus.pix_2      = pix_q[2];
  assign bus.pix_3      = pix_q[3];
  assign bus.pix_5      = pix_q[4];
  assign bus.pix_6      = pix_q[5];
  assign bus.pix_7      = pix_q[6];
  assign bus.pix_8      = pix_q[7];
  assign bus.win_addr   = win_addr_q;
  assign bus.win_border = border_q;
  assign bus.win_valid  = valid_q;

endmodule
